maxpool_2x2_stream: RTL

- 2x2, stride-2 max-pooling stage placed directly downstream of the convolution engine.
- Consumes the engine's ReLU'd feature map as a raster-order stream (default 6x6 of signed 32-bit) and emits the pooled map (default 3x3) as a raster-order stream.
- Uses valid/ready handshakes on both sides, so it can be backpressured by the dense/classifier stage that follows.

---
 rtl/maxpool_2x2_stream.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream
// 2x2, stride-2 max pooling over a raster-order stream of signed elements.
// The input map (IN_W x IN_H) arrives one element per accept; the pooled map
// ((IN_W/2) x (IN_H/2)) leaves through a single-entry output register.
// Odd trailing columns/rows are consumed and dropped (floor pooling).
//
// Datapath per accepted element (col, row):
//   even col           : element -> pair_reg
//   odd col, even row  : max(pair_reg, element) -> rowbuf[col/2]
//   odd col, odd row   : max(rowbuf[col/2], max(pair_reg, element)) -> out_data
//
// Backpressure: in_ready is low whenever a result is waiting and the consumer
// is not taking it, so a new window result can never overwrite a pending one.

module maxpool_2x2_stream #(
  parameter int IN_W   = 6,
  parameter int IN_H   = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // Geometry of the counters and of the one-row buffer of horizontal maxima.
  localparam int OUT_W = IN_W / 2;
  localparam int CW    = $clog2(IN_W);
  localparam int RW    = $clog2(IN_H);
  localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;

  logic [DATA_W-1:0] pair_reg;
  logic [DATA_W-1:0] rowbuf [OUT_W];

  logic              accept;
  logic              emit;
  logic              last_elem;
  logic              load;
  logic              buf_write;
  logic [IDX_W-1:0]  buf_idx;
  logic [DATA_W-1:0] hmax;
  logic [DATA_W-1:0] result;

  // Handshake decode. in_ready only depends on the registered state and on
  // the output register, plus the consumer's ready for pass-through.
  assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign last_elem = (row == ROW_LAST) && (col == COL_LAST);

  // Odd columns and odd rows always fall inside the pooled area: with an odd
  // dimension the dropped trailing column/row has an even index, so it only
  // ever touches pair_reg or a rowbuf entry that no later odd row reads.
  assign buf_idx   = IDX_W'(col >> 1);
  assign buf_write = accept && col[0] && !row[0];
  assign load      = accept && col[0] &&  row[0];

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  // Signed horizontal max of the pair, then vertical max against the row buffer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    hmax   = in_data;
    result = hmax;
    if ($signed(pair_reg) > $signed(in_data)) begin
      hmax = pair_reg;
    end
    result = hmax;
    if ($signed(rowbuf[buf_idx]) > $signed(hmax)) begin
      result = rowbuf[buf_idx];
    end
  end

  // Control FSM: frame sequencing and raster position counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in the block.
    if (rst) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (last_elem) begin
              state <= S_DRAIN;
            end
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Leave once nothing is pending or the pending result is taken now.
          if (!out_valid || out_ready) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Left element of each horizontal pair.
  always_ff @(posedge clk) begin
    // NOTE: pair_reg and rowbuf are deliberately not reset: each entry is
    // always written earlier in a frame than it is read, so stale contents
    // from an aborted frame can never reach out_data.
    if (accept && !col[0]) begin
      pair_reg <= in_data;
    end
  end

  // Horizontal maxima of the even row, waiting for the odd row below.
  always_ff @(posedge clk) begin
    if (buf_write) begin
      rowbuf[buf_idx] <= hmax;
    end
  end

  // Output register: a load wins over an emit in the same cycle, keeping
  // out_valid high with the new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if (emit) begin
      out_valid <= 1'b0;
    end
  end

endmodule
